// File: rtl/somador_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM state encoding,
// parameter limits and small elaboration-time helpers.
package somador_pkg;

  typedef enum logic [1:0] {OCIOSO, CALCULA, PRONTO} estado_t;

  localparam int MIN_WIDTH_A = 2;
  localparam int MAX_WIDTH_A = 32;
  localparam int MIN_WIDTH_B = 1;
  localparam int MIN_DIGITO  = 1;

  function automatic bit params_legais(input int wa, input int wb, input int dig);
    return (wa >= MIN_WIDTH_A) && (wa <= MAX_WIDTH_A) &&
           (wb >= MIN_WIDTH_B) && (wb <= wa) &&
           (dig >= MIN_DIGITO) && (dig <= wa);
  endfunction

  function automatic int num_digitos(input int wa, input int dig);
    return (wa + dig - 1) / dig;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the digit adder.
module full_adder (
  input  logic x_i,
  input  logic y_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = x_i ^ y_i ^ ci_i;
  assign co_o = (x_i & y_i) | (ci_i & (x_i ^ y_i));

endmodule

// File: rtl/somador_digito.sv
// DIGITO-bit ripple adder made of full_adder cells; also exposes the carry
// entering its top bit so the caller can derive signed overflow.
module somador_digito #(
  parameter int DIGITO = 2
) (
  input  logic [DIGITO-1:0] x_i,
  input  logic [DIGITO-1:0] y_i,
  input  logic              cin_i,
  output logic [DIGITO-1:0] soma_o,
  output logic              cout_o,
  output logic              c_topo_o
);

  logic [DIGITO:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < DIGITO; i++) begin : g_fa
    full_adder u_fa (
      .x_i  (x_i[i]),
      .y_i  (y_i[i]),
      .ci_i (c[i]),
      .s_o  (soma_o[i]),
      .co_o (c[i+1])
    );
  end

  assign cout_o   = c[DIGITO];
  assign c_topo_o = c[DIGITO-1];

endmodule

// File: rtl/somador_subtrator_serial.sv
// Digit-serial adder/subtractor: DIGITO bits per cycle, LSB first, with a
// valid/ready handshake on both sides. Define SATURACAO_EN to saturate on overflow.
module somador_subtrator_serial
  import somador_pkg::*;
#(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 4,
  parameter int DIGITO  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  input  logic               modo_sub,
  input  logic               cin_inicial,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A-1:0] s,
  output logic               cout,
  output logic               ov,
  output logic               zero
);

  localparam int N     = num_digitos(WIDTH_A, DIGITO);
  localparam int WP    = N * DIGITO;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int RESTO = WIDTH_A - (N - 1) * DIGITO;
  localparam logic [IW-1:0] ULTIMO = IW'(N - 1);

  if (!params_legais(WIDTH_A, WIDTH_B, DIGITO)) begin : g_param_ilegal
    $fatal(1, "somador_subtrator_serial: illegal WIDTH_A/WIDTH_B/DIGITO combination");
  end

  estado_t           estado_q, estado_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WP-1:0]     opa_q, opa_d, opb_q, opb_d, acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [WIDTH_A-1:0] s_q, s_d, res_final;
  logic              cout_q, cout_d, ov_q, ov_d, zero_q, zero_d;

  logic [DIGITO-1:0] xs, ys, soma;
  logic              c_out_dig, c_topo_dig, c_msb_in, c_msb_out;

  assign xs = opa_q[int'(idx_q)*DIGITO +: DIGITO];
  assign ys = opb_q[int'(idx_q)*DIGITO +: DIGITO];

  somador_digito #(.DIGITO(DIGITO)) u_digito (
    .x_i      (xs),
    .y_i      (ys),
    .cin_i    (carry_q),
    .soma_o   (soma),
    .cout_o   (c_out_dig),
    .c_topo_o (c_topo_dig)
  );

  // Operand padding above WIDTH_A is zero, so in a partial last slice the
  // first padding sum bit is exactly the carry out of bit WIDTH_A-1.
  if (RESTO == DIGITO) begin : g_fatia_cheia
    assign c_msb_out = c_out_dig;
    assign c_msb_in  = c_topo_dig;
  end else begin : g_fatia_parcial
    logic unused_topo;
    assign unused_topo = c_topo_dig;
    assign c_msb_out   = soma[RESTO];
    assign c_msb_in    = soma[RESTO-1] ^ xs[RESTO-1] ^ ys[RESTO-1];
  end

  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    s_d       = s_q;
    cout_d    = cout_q;
    ov_d      = ov_q;
    zero_d    = zero_q;
    res_final = '0;
    case (estado_q)
      OCIOSO: begin
        if (in_valid) begin
          opa_d    = WP'(a);
          opb_d    = WP'(WIDTH_A'(b) ^ {WIDTH_A{modo_sub}});
          carry_d  = cin_inicial ^ modo_sub;
          acc_d    = '0;
          idx_d    = '0;
          estado_d = CALCULA;
        end
      end
      CALCULA: begin
        acc_d[int'(idx_q)*DIGITO +: DIGITO] = soma;
        carry_d = c_out_dig;
        idx_d   = idx_q + IW'(1);
        if (idx_q == ULTIMO) begin
          res_final = acc_d[WIDTH_A-1:0];
          ov_d      = c_msb_in ^ c_msb_out;
`ifdef SATURACAO_EN
          if (ov_d) begin
            res_final = opa_q[WIDTH_A-1] ? {1'b1, {(WIDTH_A-1){1'b0}}}
                                         : {1'b0, {(WIDTH_A-1){1'b1}}};
          end
`endif
          s_d      = res_final;
          cout_d   = c_msb_out;
          zero_d   = (res_final == '0);
          idx_d    = '0;
          estado_d = PRONTO;
        end
      end
      PRONTO: begin
        if (out_ready) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= OCIOSO;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      ov_q     <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      s_q      <= s_d;
      cout_q   <= cout_d;
      ov_q     <= ov_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (estado_q == OCIOSO);
  assign out_valid = (estado_q == PRONTO);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ov        = ov_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Self-checking bench for somador_subtrator_serial (WIDTH_A=8, WIDTH_B=4, DIGITO=2):
// fixed vector table, handshake/reset sequences and random ops against an arithmetic model.
module tb_somador_subtrator_serial;

  logic       clk = 1'b0;
  logic       reset, in_valid, modo_sub, cin_inicial, out_ready;
  logic [7:0] a;
  logic [3:0] b;
  logic       in_ready, out_valid, cout, ov, zero;
  logic [7:0] s;

  int checks = 0;
  int passed = 0;
  int lat;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    bit         m;
    bit         ci;
    logic [7:0] es;
    bit         ec;
    bit         eov;
    bit         ez;
  } vec_t;

`ifdef SATURACAO_EN
  localparam logic [7:0] S_OV_ADD = 8'h7F;
  localparam logic [7:0] S_OV_SUB = 8'h80;
`else
  localparam logic [7:0] S_OV_ADD = 8'h87;
  localparam logic [7:0] S_OV_SUB = 8'h7F;
`endif

  somador_subtrator_serial #(.WIDTH_A(8), .WIDTH_B(4), .DIGITO(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .modo_sub    (modo_sub),
    .cin_inicial (cin_inicial),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .s           (s),
    .cout        (cout),
    .ov          (ov),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Plain-arithmetic reference: signed range test for ov, unsigned compare for cout.
  function automatic void modelo(input logic [7:0] ea, input logic [3:0] eb, input bit m,
                                 input bit ci, output logic [7:0] rs, output logic rc,
                                 output logic rov, output logic rz);
    int ua, ub, uc, sa, r, u;
    ua = int'(ea);
    ub = int'(eb);
    uc = ci ? 1 : 0;
    sa = ea[7] ? ua - 256 : ua;
    if (!m) begin
      u  = ua + ub + uc;
      r  = sa + ub + uc;
      rc = (u > 255);
    end else begin
      u  = ua - ub - uc;
      r  = sa - ub - uc;
      rc = (ua >= ub + uc);
    end
    rs  = u[7:0];
    rov = (r > 127) || (r < -128);
`ifdef SATURACAO_EN
    if (rov) rs = ea[7] ? 8'h80 : 8'h7F;
`endif
    rz = (rs == 8'h00);
  endfunction

  task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual === esperado) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
  endtask

  // Waits for in_ready, issues one operation, then counts edges until out_valid.
  task automatic applyStimulus(input logic [7:0] ta, input logic [3:0] tb, input bit tm, input bit tci);
    int espera;
    espera = 0;
    while (!in_ready && espera < 20) begin
      @(posedge clk); #1;
      espera++;
    end
    a           = ta;
    b           = tb;
    modo_sub    = tm;
    cin_inicial = tci;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    a           = 8'($urandom);
    b           = 4'($urandom);
    modo_sub    = 1'($urandom);
    cin_inicial = 1'($urandom);
    for (lat = 1; lat <= 20; lat++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic runAndCheck(input string nome, input logic [7:0] ta, input logic [3:0] tb,
                             input bit tm, input bit tci, input logic [7:0] es,
                             input bit ec, input bit eov, input bit ez);
    applyStimulus(ta, tb, tm, tci);
    checkOutput({nome, ".latency"}, lat, 4);
    checkOutput({nome, ".s"}, s, es);
    checkOutput({nome, ".cout"}, cout, ec);
    checkOutput({nome, ".ov"}, ov, eov);
    checkOutput({nome, ".zero"}, zero, ez);
    releaseResult();
  endtask

  initial begin
    vec_t tabela[8];
    logic [7:0] ms;
    logic mc, mov, mz;
    logic [7:0] ra;
    logic [3:0] rb;
    bit rm, rci;
    int vistos;

    tabela[0] = '{8'd100, 4'd9,  1'b0, 1'b0, 8'd109,   1'b0, 1'b0, 1'b0};
    tabela[1] = '{8'd5,   4'd7,  1'b1, 1'b0, 8'hFE,    1'b0, 1'b0, 1'b0};
    tabela[2] = '{8'd7,   4'd7,  1'b1, 1'b0, 8'h00,    1'b1, 1'b0, 1'b1};
    tabela[3] = '{8'd120, 4'd15, 1'b0, 1'b0, S_OV_ADD, 1'b0, 1'b1, 1'b0};
    tabela[4] = '{8'h80,  4'd1,  1'b1, 1'b0, S_OV_SUB, 1'b1, 1'b1, 1'b0};
    tabela[5] = '{8'hFF,  4'd15, 1'b0, 1'b1, 8'h0F,    1'b1, 1'b0, 1'b0};
    tabela[6] = '{8'h00,  4'd0,  1'b1, 1'b1, 8'hFF,    1'b0, 1'b0, 1'b0};
    tabela[7] = '{8'h00,  4'd0,  1'b0, 1'b0, 8'h00,    1'b0, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; modo_sub = 1'b0; cin_inicial = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("reset.in_ready", in_ready, 1);
    checkOutput("reset.out_valid", out_valid, 0);
    checkOutput("reset.s", s, 0);
    checkOutput("reset.flags", {cout, ov, zero}, 3'b000);

    for (int i = 0; i < 8; i++) begin
      runAndCheck($sformatf("vec%0d", i), tabela[i].a, tabela[i].b, tabela[i].m, tabela[i].ci,
                  tabela[i].es, tabela[i].ec, tabela[i].eov, tabela[i].ez);
    end

    // Backpressure: result must hold and new requests be ignored while out_ready is low.
    applyStimulus(8'd100, 4'd9, 1'b0, 1'b0);
    checkOutput("hold.latency", lat, 4);
    for (int i = 0; i < 3; i++) begin
      a = 8'h11; b = 4'd2; modo_sub = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d.out_valid", i), out_valid, 1);
      checkOutput($sformatf("hold%0d.in_ready", i), in_ready, 0);
      checkOutput($sformatf("hold%0d.s", i), s, 109);
    end
    in_valid = 1'b0;
    releaseResult();
    checkOutput("hold.in_ready_after", in_ready, 1);
    checkOutput("hold.out_valid_after", out_valid, 0);

    // Reset during the second CALCULA cycle aborts the operation.
    a = 8'd3; b = 4'd3; modo_sub = 1'b0; cin_inicial = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort.in_ready", in_ready, 1);
    checkOutput("abort.out_valid", out_valid, 0);
    checkOutput("abort.s", s, 0);
    checkOutput("abort.flags", {cout, ov, zero}, 3'b000);
    vistos = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) vistos++;
    end
    checkOutput("abort.no_out_valid", vistos, 0);
    runAndCheck("after_abort", 8'd1, 4'd1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom);
      rb  = 4'($urandom);
      rm  = 1'($urandom);
      rci = 1'($urandom);
      modelo(ra, rb, rm, rci, ms, mc, mov, mz);
      runAndCheck($sformatf("rnd%0d", i), ra, rb, rm, rci, ms, mc, mov, mz);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
